ppu_pipe: RTL and testbench

Pipelined, parametrised pixel-processing unit: the successor to the combinational single-triangle inside test. For each incoming pixel it evaluates NUM_EDGES fixed-point edge functions e = a·x + b·y + c against a double-buffered coefficient bank and flags coverage according to a winding/cull mode. It passes color and coordinates through a 3-stage valid/ready pipeline, can discard uncovered pixels, and keeps a covered-pixel counter. It sits between the pixel walker (upstream) and the color/depth write stage (downstream).

---
 rtl/ppu_pipe.sv | 182 ++++++++++++++++++
 tb/tb_ppu_pipe.sv | 371 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ppu_pipe.sv
// ppu_pipe: 3-stage edge-function coverage pipeline, double-buffered coefficients.
// Ports: coef_* / prim_swap load banks; in_* pixel in; out_* result; covered_cnt.
module ppu_pipe #(
  parameter int COORD_WIDTH = 16,
  parameter int COLOR_WIDTH = 16,
  parameter int FRAC_BITS   = 16,
  parameter int NUM_EDGES   = 3,
  parameter int CNT_WIDTH   = 32
) (
  input  logic                   clk,
  input  logic                   resetn,
  input  logic                   coef_we,
  input  logic [((NUM_EDGES > 1) ? $clog2(NUM_EDGES) : 1)-1:0] coef_idx,
  input  logic [COORD_WIDTH-1:0] coef_a,
  input  logic [COORD_WIDTH-1:0] coef_b,
  input  logic [COORD_WIDTH-1:0] coef_c,
  input  logic                   prim_swap,
  input  logic [1:0]             mode,
  input  logic                   discard,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [COORD_WIDTH-1:0] in_x,
  input  logic [COORD_WIDTH-1:0] in_y,
  input  logic [COLOR_WIDTH-1:0] in_color,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [COORD_WIDTH-1:0] out_x,
  output logic [COORD_WIDTH-1:0] out_y,
  output logic [COLOR_WIDTH-1:0] out_color,
  output logic                   out_covered,
  output logic [NUM_EDGES-1:0]   out_sign,
  output logic [CNT_WIDTH-1:0]   covered_cnt
);

  localparam int W  = COORD_WIDTH;
  localparam int PW = 2 * COORD_WIDTH;
  localparam int IW = (NUM_EDGES > 1) ? $clog2(NUM_EDGES) : 1;
  localparam logic signed [W-1:0] ZERO = '0;

  typedef logic [NUM_EDGES-1:0][W-1:0] evec_t;

  typedef struct packed {
    logic                   v;
    logic [W-1:0]           x;
    logic [W-1:0]           y;
    logic [COLOR_WIDTH-1:0] color;
    evec_t                  pa;
    evec_t                  pb;
    evec_t                  c;
  } s1_t;

  typedef struct packed {
    logic                   v;
    logic [W-1:0]           x;
    logic [W-1:0]           y;
    logic [COLOR_WIDTH-1:0] color;
    logic [NUM_EDGES-1:0]   sign;
  } s2_t;

  function automatic logic [W-1:0] mul_sh(
    input logic [W-1:0] v,
    input logic [W-1:0] k
  );
    logic signed [PW-1:0] p;
    p = PW'($signed(v)) * PW'($signed(k));
    return W'(p >>> FRAC_BITS);
  endfunction

  function automatic logic edge_neg(
    input logic [W-1:0] pa,
    input logic [W-1:0] pb,
    input logic [W-1:0] c
  );
    logic signed [W-1:0] e;
    e = pa + pb + c;
    return e < ZERO;
  endfunction

  evec_t sh_a, sh_b, sh_c;
  evec_t ac_a, ac_b, ac_c;
  s1_t   s1_d, s1_q;
  s2_t   s2_d, s2_q;
  logic  stall;
  logic  all_pos, all_neg, covered;

  assign stall    = out_valid && !out_ready;
  assign in_ready = !stall || !resetn;

  // Swap reads the shadow bank before this edge's write lands,
  // so a same-cycle write only reaches the next swap.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      sh_a <= '0;
      sh_b <= '0;
      sh_c <= '0;
      ac_a <= '0;
      ac_b <= '0;
      ac_c <= '0;
    end else begin
      if (prim_swap) begin
        ac_a <= sh_a;
        ac_b <= sh_b;
        ac_c <= sh_c;
      end
      for (int i = 0; i < NUM_EDGES; i++) begin
        if (coef_we && coef_idx == IW'(i)) begin
          sh_a[i] <= coef_a;
          sh_b[i] <= coef_b;
          sh_c[i] <= coef_c;
        end
      end
    end
  end

  always_comb begin
    s1_d       = '0;
    s1_d.v     = in_valid;
    s1_d.x     = in_x;
    s1_d.y     = in_y;
    s1_d.color = in_color;
    for (int i = 0; i < NUM_EDGES; i++) begin
      s1_d.pa[i] = mul_sh(in_x, ac_a[i]);
      s1_d.pb[i] = mul_sh(in_y, ac_b[i]);
      s1_d.c[i]  = ac_c[i];
    end
  end

  always_comb begin
    s2_d       = '0;
    s2_d.v     = s1_q.v;
    s2_d.x     = s1_q.x;
    s2_d.y     = s1_q.y;
    s2_d.color = s1_q.color;
    for (int i = 0; i < NUM_EDGES; i++) begin
      s2_d.sign[i] = edge_neg(s1_q.pa[i], s1_q.pb[i], s1_q.c[i]);
    end
  end

  always_comb begin
    all_pos = ~|s2_q.sign;
    all_neg = &s2_q.sign;
    case (mode)
      2'd1:    covered = all_pos;
      2'd2:    covered = all_neg;
      default: covered = all_pos || all_neg;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      s1_q        <= '0;
      s2_q        <= '0;
      out_valid   <= 1'b0;
      out_x       <= '0;
      out_y       <= '0;
      out_color   <= '0;
      out_covered <= 1'b0;
      out_sign    <= '0;
    end else if (!stall) begin
      s1_q      <= s1_d;
      s2_q      <= s2_d;
      out_valid <= s2_q.v && (covered || !discard);
      if (s2_q.v) begin
        out_x       <= s2_q.x;
        out_y       <= s2_q.y;
        out_color   <= s2_q.color;
        out_covered <= covered;
        out_sign    <= s2_q.sign;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      covered_cnt <= '0;
    end else if (out_valid && out_ready && out_covered
                 && covered_cnt != '1) begin
      covered_cnt <= covered_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_ppu_pipe.sv
// tb_ppu_pipe: scoreboard bench for ppu_pipe.
// Reference model computes edge signs from plain integer arithmetic.
`timescale 1ns/1ps
module tb_ppu_pipe;

  localparam int W  = 16;
  localparam int CW = 16;
  localparam int F  = 8;
  localparam int N  = 3;
  localparam int KW = 32;

  logic          clk = 1'b0;
  logic          resetn;
  logic          coef_we;
  logic [1:0]    coef_idx;
  logic [W-1:0]  coef_a, coef_b, coef_c;
  logic          prim_swap;
  logic [1:0]    mode;
  logic          discard;
  logic          in_valid, in_ready;
  logic [W-1:0]  in_x, in_y;
  logic [CW-1:0] in_color;
  logic          out_valid, out_ready;
  logic [W-1:0]  out_x, out_y;
  logic [CW-1:0] out_color;
  logic          out_covered;
  logic [N-1:0]  out_sign;
  logic [KW-1:0] covered_cnt;

  always #5 clk = ~clk;

  ppu_pipe #(
    .COORD_WIDTH(W), .COLOR_WIDTH(CW), .FRAC_BITS(F),
    .NUM_EDGES(N), .CNT_WIDTH(KW)
  ) dut (
    .clk(clk), .resetn(resetn),
    .coef_we(coef_we), .coef_idx(coef_idx),
    .coef_a(coef_a), .coef_b(coef_b), .coef_c(coef_c),
    .prim_swap(prim_swap), .mode(mode), .discard(discard),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_x(in_x), .in_y(in_y), .in_color(in_color),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_x(out_x), .out_y(out_y), .out_color(out_color),
    .out_covered(out_covered), .out_sign(out_sign),
    .covered_cnt(covered_cnt)
  );

  typedef struct {
    logic [W-1:0]  x;
    logic [W-1:0]  y;
    logic [CW-1:0] color;
    logic          cov;
    logic [N-1:0]  sign;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int fails = 0;
  int delivered = 0;
  logic [KW-1:0] exp_cnt;

  logic [W-1:0] m_sh_a[N], m_sh_b[N], m_sh_c[N];
  logic [W-1:0] m_ac_a[N], m_ac_b[N], m_ac_c[N];

  task automatic chk(input bit ok, input string name,
                     input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (!ok) begin
      fails++;
      $display("FAIL %s: got %0h want %0h", name, act, req);
    end
  endtask

  function automatic exp_t ref_px(input logic [W-1:0] x, input logic [W-1:0] y,
                                  input logic [CW-1:0] col, input logic [1:0] md);
    exp_t r;
    longint pa, pb, e;
    bit pos, neg;
    r.x = x;
    r.y = y;
    r.color = col;
    for (int i = 0; i < N; i++) begin
      pa = (longint'($signed(x)) * longint'($signed(m_ac_a[i]))) >>> F;
      pb = (longint'($signed(y)) * longint'($signed(m_ac_b[i]))) >>> F;
      e  = pa + pb + longint'($signed(m_ac_c[i]));
      r.sign[i] = e[W-1];
    end
    pos = (r.sign == '0);
    neg = (r.sign == '1);
    if (md == 2'd1) r.cov = pos;
    else if (md == 2'd2) r.cov = neg;
    else r.cov = pos || neg;
    return r;
  endfunction

  // Reference: accept pixels and track both coefficient banks.
  always @(negedge clk) begin : model
    exp_t e;
    if (!resetn) begin
      q.delete();
      for (int i = 0; i < N; i++) begin
        m_sh_a[i] = '0; m_sh_b[i] = '0; m_sh_c[i] = '0;
        m_ac_a[i] = '0; m_ac_b[i] = '0; m_ac_c[i] = '0;
      end
    end else begin
      if (in_valid && in_ready) begin
        e = ref_px(in_x, in_y, in_color, mode);
        if (!(discard && !e.cov)) q.push_back(e);
      end
      if (prim_swap) begin
        for (int i = 0; i < N; i++) begin
          m_ac_a[i] = m_sh_a[i];
          m_ac_b[i] = m_sh_b[i];
          m_ac_c[i] = m_sh_c[i];
        end
      end
      if (coef_we && coef_idx < N) begin
        m_sh_a[coef_idx] = coef_a;
        m_sh_b[coef_idx] = coef_b;
        m_sh_c[coef_idx] = coef_c;
      end
    end
  end

  // Monitor: handshake rules, held outputs, ordered scoreboard, counter.
  always @(negedge clk) begin : mon
    exp_t e;
    bit prev_stall;
    logic [63:0] held;
    if (!resetn) begin
      exp_cnt = '0;
      prev_stall = 0;
    end else begin
      chk(in_ready === !(out_valid && !out_ready), "in_ready",
          in_ready, !(out_valid && !out_ready));
      chk(covered_cnt === exp_cnt, "covered_cnt", covered_cnt, exp_cnt);
      if (prev_stall)
        chk({out_valid, out_x, out_y, out_color, out_covered, out_sign} === held,
            "hold", {out_valid, out_x, out_y, out_color, out_covered, out_sign},
            held);
      if (out_valid && out_ready) begin
        if (q.size() == 0) begin
          chk(0, "unexpected_out", {out_x, out_y}, 0);
        end else begin
          e = q.pop_front();
          delivered++;
          if (e.cov) exp_cnt = exp_cnt + 1;
          chk({out_x, out_y, out_color, out_covered, out_sign} ===
              {e.x, e.y, e.color, e.cov, e.sign}, "out_px",
              {out_x, out_y, out_color, out_covered, out_sign},
              {e.x, e.y, e.color, e.cov, e.sign});
        end
      end
      prev_stall = out_valid && !out_ready;
      held = {out_valid, out_x, out_y, out_color, out_covered, out_sign};
    end
  end

  task automatic send(input logic [W-1:0] x, input logic [W-1:0] y,
                      input logic [CW-1:0] col);
    int t;
    t = 0;
    in_valid = 1; in_x = x; in_y = y; in_color = col;
    @(negedge clk);
    while (!in_ready && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (!in_ready) chk(0, "send_timeout", t, 200);
    @(posedge clk); #1;
    in_valid = 0;
  endtask

  task automatic write_coef(input int idx, input logic [W-1:0] a,
                            input logic [W-1:0] b, input logic [W-1:0] c,
                            input bit swp);
    coef_we = 1; coef_idx = 2'(idx);
    coef_a = a; coef_b = b; coef_c = c;
    prim_swap = swp;
    @(posedge clk); #1;
    coef_we = 0; prim_swap = 0;
  endtask

  task automatic swap();
    prim_swap = 1;
    @(posedge clk); #1;
    prim_swap = 0;
  endtask

  task automatic drain();
    int t;
    t = 0;
    while (q.size() != 0 && t < 400) begin
      @(posedge clk); #1;
      t++;
    end
    chk(q.size() == 0, "drain", q.size(), 0);
    repeat (4) @(posedge clk);
    #1;
  endtask

  // Single pixel with latency and directed result check.
  task automatic one(input logic [W-1:0] x, input logic [W-1:0] y,
                     input logic [N-1:0] sg, input bit cv, input string nm);
    send(x, y, 16'($urandom));
    chk(out_valid === 1'b0, {nm, "_n1"}, out_valid, 0);
    @(posedge clk); #1;
    chk(out_valid === 1'b0, {nm, "_n2"}, out_valid, 0);
    @(posedge clk); #1;
    chk(out_valid === 1'b1 && out_sign === sg && out_covered === cv, nm,
        {out_valid, out_sign, out_covered}, {1'b1, sg, cv});
    @(posedge clk); #1;
  endtask

  initial begin
    int d0;
    logic [KW-1:0] c0;
    resetn = 0; coef_we = 0; coef_idx = 0;
    coef_a = 0; coef_b = 0; coef_c = 0;
    prim_swap = 0; mode = 0; discard = 0;
    in_valid = 0; in_x = 0; in_y = 0; in_color = 0;
    out_ready = 1;
    repeat (3) @(posedge clk);
    #1;
    chk(in_ready === 1'b1, "rst_in_ready", in_ready, 1);
    chk(out_valid === 1'b0 && out_covered === 1'b0, "rst_valid",
        {out_valid, out_covered}, 0);
    chk({out_x, out_y, out_color, out_sign} === '0, "rst_data",
        {out_x, out_y, out_color, out_sign}, 0);
    chk(covered_cnt === '0, "rst_cnt", covered_cnt, 0);
    resetn = 1;
    @(posedge clk); #1;
    one(7, 9, 3'b000, 1, "rst_bank_cov");

    write_coef(0, 16'h0100, 16'h0000, 16'hFFFE, 0);
    write_coef(1, 16'h0000, 16'h0100, 16'hFFFE, 0);
    write_coef(2, 16'hFF00, 16'hFF00, 16'd20, 0);
    swap();
    one(5, 5, 3'b000, 1, "px55");
    one(1, 5, 3'b001, 0, "px15");
    one(2, 2, 3'b000, 1, "px22_zero");

    write_coef(0, 16'hFF00, 16'h0000, 16'h0002, 0);
    write_coef(1, 16'h0000, 16'hFF00, 16'h0002, 0);
    write_coef(2, 16'h0100, 16'h0100, 16'hFFEC, 0);
    swap();
    mode = 0; one(5, 5, 3'b111, 1, "neg_m0");
    mode = 1; one(5, 5, 3'b111, 0, "neg_m1");
    mode = 2; one(5, 5, 3'b111, 1, "neg_m2");
    mode = 3; one(5, 5, 3'b111, 1, "neg_m3");
    mode = 0;

    d0 = delivered;
    fork
      begin
        repeat (4) @(posedge clk);
        #1 out_ready = 0;
        repeat (3) @(posedge clk);
        #1 out_ready = 1;
      end
      begin
        for (int i = 0; i < 8; i++) send(16'(i), 16'(i * 3), 16'(100 + i));
      end
    join
    drain();
    chk(delivered - d0 == 8, "stall_count", delivered - d0, 8);

    discard = 1;
    d0 = delivered;
    c0 = covered_cnt;
    for (int i = 0; i < 8; i++) begin
      if (i % 2 == 0) send(5, 5, 16'(200 + i));
      else send(1, 5, 16'(200 + i));
    end
    drain();
    discard = 0;
    chk(delivered - d0 == 4, "discard_count", delivered - d0, 4);
    chk(covered_cnt - c0 == 4, "discard_cnt", covered_cnt - c0, 4);

    fork
      begin
        for (int i = 0; i < 12; i++)
          send(16'($urandom_range(0, 40)), 16'($urandom_range(0, 40)),
               16'($urandom));
      end
      begin
        for (int i = 0; i < 3; i++)
          write_coef(i, 16'($urandom), 16'($urandom), 16'($urandom), 0);
        repeat (2) @(posedge clk);
        #1;
        swap();
      end
    join
    drain();

    for (int i = 0; i < 3; i++) write_coef(i, 0, 0, 16'd5, 0);
    write_coef(0, 0, 0, 16'hFFFB, 1);
    one(3, 4, 3'b000, 1, "ws_old");
    swap();
    one(3, 4, 3'b001, 0, "ws_new");
    write_coef(3, 0, 0, 16'hFFFB, 0);
    swap();
    one(3, 4, 3'b001, 0, "idx_ignored");

    for (int i = 0; i < 3; i++) write_coef(i, 16'h7FFF, 16'h0000, 16'h7FFF, 0);
    swap();
    one(16'h0100, 0, 3'b111, 1, "wrap_sum");
    send(16'h7FFF, 16'h7FFF, 16'h1234);
    drain();

    for (int ph = 0; ph < 4; ph++) begin
      mode = 2'(ph);
      discard = 1'($urandom_range(0, 1));
      fork
        begin
          for (int i = 0; i < 60; i++) begin
            if ($urandom_range(0, 3) == 0) begin
              @(posedge clk); #1;
            end
            send(16'($urandom), 16'($urandom), 16'($urandom));
          end
        end
        begin
          repeat (15) begin
            repeat ($urandom_range(1, 6)) @(posedge clk);
            #1;
            write_coef($urandom_range(0, 3), 16'($urandom), 16'($urandom),
                       16'($urandom), 1'($urandom_range(0, 1)));
          end
        end
        begin
          repeat (120) begin
            @(posedge clk); #1;
            out_ready = ($urandom_range(0, 2) != 0);
          end
          out_ready = 1;
        end
      join
      drain();
    end
    mode = 0;
    discard = 0;

    fork
      begin
        for (int i = 0; i < 10; i++)
          send(16'($urandom), 16'($urandom), 16'($urandom));
      end
      begin
        repeat (6) @(posedge clk);
        #1 resetn = 0;
        @(posedge clk); #1;
        chk(out_valid === 1'b0, "midrst_valid", out_valid, 0);
        chk(covered_cnt === '0, "midrst_cnt", covered_cnt, 0);
        resetn = 1;
      end
    join
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures",
             checks, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running want finished");
    $fatal(1, "timeout");
  end

endmodule
